// File: rtl/cam_capture_if.sv
// Camera-side bus and pixel output stream of the capture front end.
// Pixel stream is valid-only: pixel_valid strobes one cycle per pixel with no backpressure, so the sink must take every strobe.
interface cam_capture_if;
  logic        vsync;
  logic        href;
  logic [7:0]  cam_data;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        colr;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_done;
  logic        overflow;
  logic [1:0]  state_dbg;

  modport master (
    output vsync, href, cam_data,
    input  pixel_data, pixel_valid, colr, x, y, frame_done, overflow, state_dbg
  );

  modport slave (
    input  vsync, href, cam_data,
    output pixel_data, pixel_valid, colr, x, y, frame_done, overflow, state_dbg
  );
endinterface

// File: rtl/cam_capture.sv
// OV7670-style capture: pairs bus bytes into RGB565 pixels, tracks x/y and flags
// pixels inside the region of interest for the colour classifier.
module cam_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int WIN_X0      = 280,
  parameter int WIN_X1      = 359,
  parameter int WIN_Y0      = 200,
  parameter int WIN_Y1      = 279,
  parameter int SKIP_FRAMES = 2
) (
  input  logic p_clock,
  input  logic rst,
  cam_capture_if.slave cam
);

  typedef enum logic [1:0] {
    S_SKIP    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_ACTIVE  = 2'd2
  } state_t;

  localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM    = 9'(V_ACTIVE);
  localparam logic [9:0] WX0      = 10'(WIN_X0);
  localparam logic [9:0] WX1      = 10'(WIN_X1);
  localparam logic [8:0] WY0      = 9'(WIN_Y0);
  localparam logic [8:0] WY1      = 9'(WIN_Y1);
  localparam logic [7:0] SKIP_LIM = 8'(SKIP_FRAMES);

  state_t      state_q, state_d;
  logic        vsync_r, href_r;
  logic [7:0]  skip_cnt;
  logic        phase;
  logic        line_has_byte;
  logic [7:0]  hi_byte;
  logic [9:0]  x_cnt;
  logic [8:0]  y_cnt;

  logic [15:0] pix_q;
  logic        valid_q;
  logic        colr_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic        done_q;
  logic        ovf_q;

  logic vs_rise, vs_fall, href_fall;
  logic byte_en, in_range, in_win;

  assign vs_rise   = cam.vsync & ~vsync_r;
  assign vs_fall   = ~cam.vsync & vsync_r;
  assign href_fall = ~cam.href & href_r;

  // Bytes are only taken on active lines; blanking (vsync high) suppresses them.
  assign byte_en  = (state_q == S_ACTIVE) && cam.href && !cam.vsync;
  assign in_range = (x_cnt < H_LIM) && (y_cnt < V_LIM);
  assign in_win   = (x_cnt >= WX0) && (x_cnt <= WX1) &&
                    (y_cnt >= WY0) && (y_cnt <= WY1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SKIP: begin
        if (skip_cnt == SKIP_LIM)
          state_d = S_WAIT_VS;
        else if (vs_rise && (skip_cnt + 8'd1 == SKIP_LIM))
          state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs_fall)
          state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (vs_rise)
          state_d = S_WAIT_VS;
      end
      default: state_d = S_SKIP;
    endcase
  end

  always_ff @(posedge p_clock or posedge rst) begin
    if (rst)
      state_q <= S_SKIP;
    else
      state_q <= state_d;
  end

  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      vsync_r  <= 1'b0;
      href_r   <= 1'b0;
      skip_cnt <= 8'd0;
    end else begin
      vsync_r <= cam.vsync;
      href_r  <= cam.href;
      if (state_q == S_SKIP && vs_rise && skip_cnt != SKIP_LIM)
        skip_cnt <= skip_cnt + 8'd1;
    end
  end

  // Datapath: byte pairing, coordinate counters and the registered pixel strobe.
  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      phase         <= 1'b0;
      line_has_byte <= 1'b0;
      hi_byte       <= 8'd0;
      x_cnt         <= 10'd0;
      y_cnt         <= 9'd0;
      pix_q         <= 16'd0;
      valid_q       <= 1'b0;
      colr_q        <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      colr_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_WAIT_VS: begin
          if (vs_fall) begin
            x_cnt         <= 10'd0;
            y_cnt         <= 9'd0;
            phase         <= 1'b0;
            line_has_byte <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (vs_rise) begin
            done_q        <= 1'b1;
            phase         <= 1'b0;
            line_has_byte <= 1'b0;
          end else if (href_fall) begin
            // An odd trailing byte is dropped by forcing the phase back to 0.
            x_cnt         <= 10'd0;
            phase         <= 1'b0;
            line_has_byte <= 1'b0;
            if (line_has_byte && y_cnt != V_LIM)
              y_cnt <= y_cnt + 9'd1;
          end else if (byte_en) begin
            line_has_byte <= 1'b1;
            if (!phase) begin
              hi_byte <= cam.cam_data;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (in_range) begin
                pix_q   <= {hi_byte, cam.cam_data};
                valid_q <= 1'b1;
                colr_q  <= in_win;
                x_q     <= x_cnt;
                y_q     <= y_cnt;
              end else begin
                ovf_q <= 1'b1;
              end
              if (x_cnt != H_LIM)
                x_cnt <= x_cnt + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cam.pixel_data  = pix_q;
  assign cam.pixel_valid = valid_q;
  assign cam.colr        = colr_q;
  assign cam.x           = x_q;
  assign cam.y           = y_q;
  assign cam.frame_done  = done_q;
  assign cam.overflow    = ovf_q;
  assign cam.state_dbg   = state_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: two differently parameterised instances share one camera
// stream; a frame-level model predicts every strobe and frame_done with its cycle.
module tb_cam_capture;

  // ---------------- clock / reset ----------------
  logic       p_clock = 1'b0;
  logic       rst;
  logic       vsync;
  logic       href;
  logic [7:0] cam_data;
  int         ncyc = 0;

  always #5 p_clock = ~p_clock;
  always @(posedge p_clock) ncyc <= ncyc + 1;

  // Instance A: full-size line, tiny window, two settling frames.
  localparam int A_H = 640, A_V = 480, A_S = 2;
  localparam int A_X0 = 2, A_X1 = 3, A_Y0 = 1, A_Y1 = 1;
  // Instance B: undersized line/frame to exercise dropping and overflow.
  localparam int B_H = 4, B_V = 3, B_S = 0;
  localparam int B_X0 = 1, B_X1 = 2, B_Y0 = 0, B_Y1 = 0;

  cam_capture_if ifa ();
  cam_capture_if ifb ();

  assign ifa.vsync = vsync;  assign ifa.href = href;  assign ifa.cam_data = cam_data;
  assign ifb.vsync = vsync;  assign ifb.href = href;  assign ifb.cam_data = cam_data;

  cam_capture #(.H_ACTIVE(A_H), .V_ACTIVE(A_V), .WIN_X0(A_X0), .WIN_X1(A_X1),
                .WIN_Y0(A_Y0), .WIN_Y1(A_Y1), .SKIP_FRAMES(A_S))
    dut_a (.p_clock(p_clock), .rst(rst), .cam(ifa));

  cam_capture #(.H_ACTIVE(B_H), .V_ACTIVE(B_V), .WIN_X0(B_X0), .WIN_X1(B_X1),
                .WIN_Y0(B_Y0), .WIN_Y1(B_Y1), .SKIP_FRAMES(B_S))
    dut_b (.p_clock(p_clock), .rst(rst), .cam(ifb));

  logic        pv [2];
  logic        cl [2];
  logic        fd [2];
  logic        ov [2];
  logic [15:0] pd [2];
  logic [9:0]  xs [2];
  logic [8:0]  ys [2];

  assign pv[0] = ifa.pixel_valid;  assign pv[1] = ifb.pixel_valid;
  assign cl[0] = ifa.colr;         assign cl[1] = ifb.colr;
  assign fd[0] = ifa.frame_done;   assign fd[1] = ifb.frame_done;
  assign ov[0] = ifa.overflow;     assign ov[1] = ifb.overflow;
  assign pd[0] = ifa.pixel_data;   assign pd[1] = ifb.pixel_data;
  assign xs[0] = ifa.x;            assign xs[1] = ifb.x;
  assign ys[0] = ifa.y;            assign ys[1] = ifb.y;

  // ---------------- scoreboard state ----------------
  // pixel record: {stamp[31:0], pixel[15:0], x[9:0], y[8:0], colr}
  logic [67:0] exp_q [2][$];
  // frame record: {stamp[31:0], overflow}
  logic [32:0] fd_q [2][$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int   frame_idx;
  logic ovf_m [2];

  // Frame f (lines followed by a vsync pulse) follows f vsync pulses since reset.
  // It is captured once the settle count is reached and a vsync fall has been seen.
  function automatic logic captured(int f, int s);
    return (f >= s) && (f >= 1);
  endfunction

  task automatic model_pixel(input int line, input int px, input logic [15:0] d);
    int lim_h, lim_v, s, x0, x1, y0, y1;
    logic win;
    for (int i = 0; i < 2; i++) begin
      lim_h = (i == 0) ? A_H : B_H;   lim_v = (i == 0) ? A_V : B_V;
      s     = (i == 0) ? A_S : B_S;
      x0 = (i == 0) ? A_X0 : B_X0;    x1 = (i == 0) ? A_X1 : B_X1;
      y0 = (i == 0) ? A_Y0 : B_Y0;    y1 = (i == 0) ? A_Y1 : B_Y1;
      if (captured(frame_idx, s)) begin
        if (px < lim_h && line < lim_v) begin
          win = (px >= x0) && (px <= x1) && (line >= y0) && (line <= y1);
          exp_q[i].push_back({32'(ncyc + 1), d, 10'(px), 9'(line), win});
        end else begin
          ovf_m[i] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] pick_byte(input int line, input int b);
    if (b == 0) return (line % 2 == 1) ? 8'h07 : 8'hF8;
    if (b == 1) return (line % 2 == 1) ? 8'hE0 : 8'h00;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic drive_line(input int line, input int nbytes);
    logic [7:0] hi;
    for (int b = 0; b < nbytes; b++) begin
      @(negedge p_clock);
      href     = 1'b1;
      cam_data = pick_byte(line, b);
      if (b % 2 == 0) hi = cam_data;
      else model_pixel(line, b / 2, {hi, cam_data});
    end
    @(negedge p_clock);
    href = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge p_clock);
  endtask

  task automatic drive_vsync();
    @(negedge p_clock);
    vsync = 1'b1;
    if (captured(frame_idx, A_S)) fd_q[0].push_back({32'(ncyc + 1), ovf_m[0]});
    if (captured(frame_idx, B_S)) fd_q[1].push_back({32'(ncyc + 1), ovf_m[1]});
    repeat (3) @(negedge p_clock);
    vsync = 1'b0;
    repeat (4) @(negedge p_clock);
    frame_idx++;
  endtask

  task automatic drive_frame(input int nlines, input int fixed_bytes);
    for (int l = 0; l < nlines; l++)
      drive_line(l, (fixed_bytes > 0) ? fixed_bytes : $urandom_range(1, 19));
    drive_vsync();
  endtask

  task automatic check_zero(input string name, input int i, input logic [15:0] act);
    checks++;
    if (act !== 16'd0) begin
      errors++;
      $display("FAIL rst_%s dut%0d: got %h expected 0", name, i, act);
    end
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      check_zero("pixel_valid", i, 16'(pv[i]));
      check_zero("colr", i, 16'(cl[i]));
      check_zero("pixel_data", i, pd[i]);
      check_zero("x", i, 16'(xs[i]));
      check_zero("y", i, 16'(ys[i]));
      check_zero("frame_done", i, 16'(fd[i]));
      check_zero("overflow", i, 16'(ov[i]));
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [67:0] got, exp;
    logic [32:0] fgot, fexp;
    forever begin
      @(negedge p_clock);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          while (exp_q[i].size() > 0 && int'(exp_q[i][0][67:36]) < ncyc) begin
            checks++; errors++;
            exp = exp_q[i].pop_front();
            $display("FAIL missed_strobe dut%0d: no pixel at cycle %0d, expected data %h x %0d y %0d",
                     i, exp[67:36], exp[35:20], exp[19:10], exp[9:1]);
          end
          while (fd_q[i].size() > 0 && int'(fd_q[i][0][32:1]) < ncyc) begin
            checks++; errors++;
            fexp = fd_q[i].pop_front();
            $display("FAIL missed_frame_done dut%0d: none at cycle %0d", i, fexp[32:1]);
          end
          if (pv[i]) begin
            checks++;
            got = {32'(ncyc), pd[i], xs[i], ys[i], cl[i]};
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_strobe dut%0d: cycle %0d data %h x %0d y %0d, expected no strobe",
                       i, ncyc, pd[i], xs[i], ys[i]);
            end else begin
              exp = exp_q[i].pop_front();
              if (got !== exp) begin
                errors++;
                $display("FAIL pixel dut%0d: got cyc %0d data %h x %0d y %0d colr %b, expected cyc %0d data %h x %0d y %0d colr %b",
                         i, got[67:36], got[35:20], got[19:10], got[9:1], got[0],
                         exp[67:36], exp[35:20], exp[19:10], exp[9:1], exp[0]);
              end
            end
          end else if (cl[i]) begin
            checks++; errors++;
            $display("FAIL colr_without_valid dut%0d: colr 1 at cycle %0d, expected 0", i, ncyc);
          end
          if (fd[i]) begin
            checks++;
            fgot = {32'(ncyc), ov[i]};
            if (fd_q[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_frame_done dut%0d: cycle %0d, expected none", i, ncyc);
            end else begin
              fexp = fd_q[i].pop_front();
              if (fgot !== fexp) begin
                errors++;
                $display("FAIL frame_done dut%0d: got cyc %0d overflow %b, expected cyc %0d overflow %b",
                         i, fgot[32:1], fgot[0], fexp[32:1], fexp[0]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [7:0] hi_b;
  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; cam_data = 8'd0;
    frame_idx = 0; ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
    repeat (3) @(negedge p_clock);
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge p_clock);

    // Settling frames then captured frames of 4 lines x 8 pixels.
    for (int f = 0; f < 3; f++) drive_frame(4, 16);
    // Randomised geometry including odd-length lines and overlong lines.
    for (int f = 0; f < 3; f++) drive_frame($urandom_range(2, 5), 0);

    // Asynchronous reset in the middle of a captured line, after 3 pixels.
    for (int b = 0; b < 7; b++) begin
      @(negedge p_clock);
      href     = 1'b1;
      cam_data = 8'($urandom_range(0, 255));
      if (b % 2 == 0) hi_b = cam_data;
      else model_pixel(0, b / 2, {hi_b, cam_data});
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    frame_idx = 0; ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
    @(negedge p_clock);
    href = 1'b0;
    repeat (2) @(negedge p_clock);
    rst = 1'b0;

    // Rest of the interrupted frame is discarded, then capture resumes.
    drive_frame(2, 0);
    for (int f = 0; f < 3; f++) drive_frame($urandom_range(2, 5), 0);

    repeat (5) @(negedge p_clock);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL pending_pixels dut%0d: got %0d left, expected 0", i, exp_q[i].size());
      end
      checks++;
      if (fd_q[i].size() != 0) begin
        errors++;
        $display("FAIL pending_frames dut%0d: got %0d left, expected 0", i, fd_q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
